iomem_spi_master: RTL



---
 rtl/iomem_spi_master.sv | 124 ++++++++++++
 1 files changed

// File: rtl/iomem_spi_master.sv
// Memory-mapped SPI master (mode 0, MSB first, 8-bit frames) on the PicoRV32 iomem bus.
// Registered one-cycle ack; DATA writes issued while busy stall until the frame ends.
module iomem_spi_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter logic [7:0]  CLK_DIV   = 8'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sclk_q, sclk_d, mosi_q, mosi_d;
  logic [7:0]  div_q, div_d;
  logic        cs_en_q, cs_en_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  tx_q, tx_d, rx_sh_q, rx_sh_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  cnt_q, cnt_d, h_q, h_d;

  logic       sel, wr, data_wr, acc, start, half_done, busy, rx_set, rd_data;
  logic [1:0] off;
  logic [7:0] div_eff;
  logic       unused_bits;

  assign sel       = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
  assign off       = iomem_addr[3:2];
  assign wr        = |iomem_wstrb;
  assign busy      = (state_q != S_IDLE);
  assign data_wr   = sel && !ready_q && wr && (off == 2'd0) && iomem_wstrb[0];
  assign acc       = sel && !ready_q && !(data_wr && busy);
  assign start     = data_wr && !busy;
  assign rd_data   = acc && !wr && (off == 2'd0);
  // h_q is latched at every half-period boundary so divider writes never stretch a live half-period
  assign half_done = (cnt_q == h_q - 8'd1);
  assign div_eff   = (div_q == 8'd0) ? 8'd1 : div_q;
  assign unused_bits = ^{iomem_addr[1:0], iomem_wdata[31:9]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOW;
      S_LOW:   if (half_done) state_d = S_HIGH;
      S_HIGH:  if (half_done) state_d = (bitcnt_q == 4'd8) ? S_IDLE : S_LOW;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d = tx_q; rx_sh_d = rx_sh_q; bitcnt_d = bitcnt_q; cnt_d = cnt_q; h_d = h_q;
    sclk_d = sclk_q; mosi_d = mosi_q; rx_byte_d = rx_byte_q; rx_set = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        tx_d = iomem_wdata[7:0]; mosi_d = iomem_wdata[7];
        bitcnt_d = 4'd0; cnt_d = 8'd0; h_d = div_eff;
      end
      S_LOW: if (half_done) begin
        sclk_d = 1'b1; rx_sh_d = {rx_sh_q[6:0], spi_miso};
        bitcnt_d = bitcnt_q + 4'd1; cnt_d = 8'd0; h_d = div_eff;
      end else cnt_d = cnt_q + 8'd1;
      S_HIGH: if (half_done) begin
        sclk_d = 1'b0; cnt_d = 8'd0; h_d = div_eff;
        if (bitcnt_q == 4'd8) begin
          rx_byte_d = rx_sh_q; rx_set = 1'b1;
        end else begin
          tx_d = {tx_q[6:0], 1'b0}; mosi_d = tx_q[6];
        end
      end else cnt_d = cnt_q + 8'd1;
      default: ;
    endcase

    ready_d = acc; rdata_d = 32'd0; div_d = div_q; cs_en_d = cs_en_q;
    if (acc && !wr) begin
      case (off)
        2'd0:    rdata_d = {24'd0, rx_byte_d};
        2'd1:    rdata_d = {30'd0, rx_valid_q, busy};
        2'd2:    rdata_d = {23'd0, cs_en_q, div_q};
        default: rdata_d = 32'd0;
      endcase
    end
    if (acc && wr && off == 2'd2) begin
      if (iomem_wstrb[0]) div_d = iomem_wdata[7:0];
      if (iomem_wstrb[1]) cs_en_d = iomem_wdata[8];
    end
    // a completing frame beats a same-cycle DATA read clearing the flag
    rx_valid_d = rx_set ? 1'b1 : (rd_data ? 1'b0 : rx_valid_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0; rdata_q <= 32'd0; sclk_q <= 1'b0; mosi_q <= 1'b0;
      div_q <= CLK_DIV; cs_en_q <= 1'b0; rx_byte_q <= 8'd0; rx_valid_q <= 1'b0;
      tx_q <= 8'd0; rx_sh_q <= 8'd0; bitcnt_q <= 4'd0; cnt_q <= 8'd0; h_q <= 8'd1;
    end else begin
      ready_q <= ready_d; rdata_q <= rdata_d; sclk_q <= sclk_d; mosi_q <= mosi_d;
      div_q <= div_d; cs_en_q <= cs_en_d; rx_byte_q <= rx_byte_d; rx_valid_q <= rx_valid_d;
      tx_q <= tx_d; rx_sh_q <= rx_sh_d; bitcnt_q <= bitcnt_d; cnt_q <= cnt_d; h_q <= h_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign spi_sclk    = sclk_q;
  assign spi_mosi    = mosi_q;
  assign spi_cs_n    = ~cs_en_q;
endmodule
